// File: rtl/qspi_matrix_mult_pkg.sv
// Shared types and constants for the QSPI 2x2 matrix multiplier.
package qspi_matrix_mult_pkg;
  typedef enum logic [2:0] {
    IDLE, CMD, WRITE, COMPUTE, READ, IGNORE, WAITCS
  } state_t;

  localparam logic [3:0] CMD_WRITE = 4'h1;
  localparam logic [3:0] CMD_READ  = 4'h2;

  localparam int ELEM_W           = 8;
  localparam int RES_W            = 16;
  localparam int NIBBLES_PER_XFER = 16;
endpackage

// File: rtl/qspi_matrix_mult_dot2.sv
// Two-term unsigned dot product a0*b0 + a1*b1 with a full 17-bit sum.
import qspi_matrix_mult_pkg::*;

module dot2_u8 (
  input  logic [ELEM_W-1:0] a0,
  input  logic [ELEM_W-1:0] b0,
  input  logic [ELEM_W-1:0] a1,
  input  logic [ELEM_W-1:0] b1,
  output logic [RES_W:0]    sum
);
  logic [RES_W-1:0] p0, p1;

  // Zero-extend before multiplying so the products are full 16-bit.
  always_comb begin
    p0  = {8'd0, a0} * {8'd0, b0};
    p1  = {8'd0, a1} * {8'd0, b1};
    sum = {1'b0, p0} + {1'b0, p1};
  end
endmodule

// File: rtl/qspi_matrix_mult.sv
// 2x2 u8 matrix multiplier loaded and read back over a 4-bit serial link.
import qspi_matrix_mult_pkg::*;

module qspi_matrix_mult (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  logic             unused_ok;
  logic [1:0]       cs_q, sclk_q;
  logic [1:0][3:0]  din_q;
  logic             sclk_d;
  logic             cs_s, rise, fall;
  logic [3:0]       din;

  state_t           state, state_n;
  logic [4:0]       cnt;
  logic [1:0]       cidx;
  logic [3:0]       hi, dout, rnib;
  logic             done, ovf;
  logic [7:0][ELEM_W-1:0] mat;  // 0..3 = A00..A11, 4..7 = B00..B11
  logic [3:0][RES_W-1:0]  res;  // C00, C01, C10, C11
  logic [RES_W-1:0] rword;
  logic [RES_W:0]   sum;

  assign unused_ok = &{1'b0, ena, ui_in[7:2], uio_in[7:4]};

  assign cs_s = cs_q[1];
  assign din  = din_q[1];
  assign rise = sclk_q[1] & ~sclk_d;
  assign fall = ~sclk_q[1] & sclk_d;

  // Two-flop synchronizers plus sclk edge history; cs_n idles deasserted.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cs_q   <= 2'b11;
      sclk_q <= '0;
      din_q  <= '0;
      sclk_d <= 1'b0;
    end else begin
      cs_q   <= {cs_q[0], ui_in[0]};
      sclk_q <= {sclk_q[0], ui_in[1]};
      din_q  <= {din_q[0], uio_in[3:0]};
      sclk_d <= sclk_q[1];
    end

  // One shared dot-product unit, operands picked by the result index.
  dot2_u8 u_dot (
    .a0 (mat[{1'b0, cidx[1], 1'b0}]),
    .b0 (mat[{1'b1, 1'b0, cidx[0]}]),
    .a1 (mat[{1'b0, cidx[1], 1'b1}]),
    .b1 (mat[{1'b1, 1'b1, cidx[0]}]),
    .sum(sum)
  );

  // State register.
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_n;

  // Next-state logic; deselect aborts everything except an in-flight compute.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (!cs_s) state_n = CMD;
      CMD:
        if (cs_s) state_n = IDLE;
        else if (rise)
          case (din)
            CMD_WRITE: state_n = WRITE;
            CMD_READ:  state_n = READ;
            default:   state_n = IGNORE;
          endcase
      WRITE:
        if (cs_s) state_n = IDLE;
        else if (rise && cnt == 5'(NIBBLES_PER_XFER - 1)) state_n = COMPUTE;
      COMPUTE: if (cidx == 2'd3) state_n = cs_s ? IDLE : WAITCS;
      READ, IGNORE, WAITCS: if (cs_s) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Read nibble selection: element cnt[3:2], most significant nibble first.
  always_comb begin
    rword = res[cnt[3:2]];
    rnib  = 4'd0;
    case (cnt[1:0])
      2'd0: rnib = rword[15:12];
      2'd1: rnib = rword[11:8];
      2'd2: rnib = rword[7:4];
      2'd3: rnib = rword[3:0];
      default: rnib = 4'd0;
    endcase
  end

  // Datapath: nibble counter, operand loading, compute, read shifting.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt  <= '0;
      cidx <= '0;
      hi   <= '0;
      dout <= '0;
      done <= 1'b0;
      ovf  <= 1'b0;
      mat  <= '0;
      res  <= '0;
    end else begin
      case (state)
        CMD:
          if (!cs_s && rise) begin
            cnt  <= '0;
            cidx <= '0;
            dout <= '0;
            if (din == CMD_WRITE) begin
              done <= 1'b0;
              ovf  <= 1'b0;
            end
          end
        WRITE:
          if (!cs_s && rise) begin
            cnt <= cnt + 5'd1;
            if (!cnt[0]) hi <= din;
            else         mat[cnt[3:1]] <= {hi, din};
          end
        COMPUTE: begin
          res[cidx] <= sum[RES_W-1:0];
          if (sum[RES_W]) ovf <= 1'b1;
          cidx <= cidx + 2'd1;
          if (cidx == 2'd3) done <= 1'b1;
        end
        READ:
          if (fall) begin
            if (!cnt[4]) begin
              dout <= rnib;
              cnt  <= cnt + 5'd1;
            end else begin
              dout <= '0;
            end
          end
        default: ;
      endcase
    end

  assign uo_out  = {5'd0, ovf, done, state == COMPUTE};
  assign uio_out = {4'd0, dout};
  assign uio_oe  = {4'd0, {4{(state == READ) && !cs_s}}};
endmodule

// File: tb/tb_qspi_matrix_mult.sv
// Directed bench for qspi_matrix_mult: loads matrices, reads results.
module tb_qspi_matrix_mult;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b1;
  logic       cs_n = 1'b1, sclk = 1'b0;
  logic [3:0] dq = 4'd0;
  logic [7:0] ui_in, uio_in;
  logic [7:0] uo_out, uio_out, uio_oe;

  int n_cmp = 0, n_bad = 0, busy_cnt = 0;

  assign ui_in  = {6'd0, sclk, cs_n};
  assign uio_in = {4'd0, dq};

  always #5 clk = ~clk;

  // Running count of cycles with busy high.
  always @(negedge clk) if (uo_out[0]) busy_cnt++;

  qspi_matrix_mult dut (
    .clk(clk), .rst(rst), .ena(ena), .ui_in(ui_in), .uo_out(uo_out),
    .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic nib(input logic [3:0] v);
    sclk = 1'b0; dq = v; wait_n(6);
    sclk = 1'b1; wait_n(6);
  endtask

  task automatic start(input logic [3:0] c);
    cs_n = 1'b0; wait_n(4);
    nib(c);
  endtask

  task automatic stop();
    cs_n = 1'b1; wait_n(6);
    sclk = 1'b0; wait_n(6);
  endtask

  task automatic wr_mat(input logic [63:0] m);
    start(4'h1);
    for (int k = 0; k < 16; k++) nib(m[63-4*k -: 4]);
    stop();
    wait_n(4);
  endtask

  task automatic rd_res(output logic [63:0] r, output logic [7:0] oe);
    r = '0; oe = '0;
    start(4'h2);
    for (int k = 0; k < 16; k++) begin
      sclk = 1'b0; wait_n(6);
      if (k == 0) oe = uio_oe;
      r[63-4*k -: 4] = uio_out[3:0];
      sclk = 1'b1; wait_n(6);
    end
    stop();
  endtask

  task automatic chk_res(input string tag, input logic [63:0] r, input logic [63:0] e);
    for (int i = 0; i < 4; i++)
      chk($sformatf("%s_c%0d", tag, i), 32'(r[63-16*i -: 16]), 32'(e[63-16*i -: 16]));
  endtask

  logic [63:0] r;
  logic [7:0]  oe;
  int          b;
  bit          seen;

  initial begin
    // reset state
    wait_n(3);
    chk("rst_uo", 32'(uo_out), 32'h00);
    chk("rst_uio_out", 32'(uio_out), 32'h00);
    chk("rst_oe", 32'(uio_oe), 32'h00);
    rst = 1'b0; wait_n(4);
    chk("idle_uo", 32'(uo_out), 32'h00);

    // A=[[1,2],[3,4]] B=[[5,6],[7,8]]
    b = busy_cnt;
    wr_mat(64'h01020304_05060708);
    chk("t1_busy", 32'(busy_cnt - b), 32'd4);
    chk("t1_flags", 32'(uo_out), 32'h02);
    rd_res(r, oe);
    chk_res("t1", r, 64'h0013_0016_002B_0032);
    chk("t1_oe", 32'(oe), 32'h0F);
    chk("t1_oe_off", 32'(uio_oe), 32'h00);

    // all 0xFF: 2*255*255 = 0x1FC02
    b = busy_cnt;
    wr_mat({8{8'hFF}});
    chk("t2_busy", 32'(busy_cnt - b), 32'd4);
    chk("t2_flags", 32'(uo_out), 32'h06);
    rd_res(r, oe);
    chk_res("t2", r, {4{16'hFC02}});

    // identity times [[9,10],[11,12]]; overflow cleared by the write command
    wr_mat(64'h01000001_090A0B0C);
    chk("t3_flags", 32'(uo_out), 32'h02);
    rd_res(r, oe);
    chk_res("t3", r, 64'h0009_000A_000B_000C);
    chk("t3_oe", 32'(oe), 32'h0F);
    chk("t3_oe_off", 32'(uio_oe), 32'h00);

    // aborted write: no compute, done cleared
    b = busy_cnt;
    start(4'h1);
    for (int k = 0; k < 6; k++) nib(4'h5);
    stop();
    wait_n(10);
    chk("t4_busy", 32'(busy_cnt - b), 32'd0);
    chk("t4_flags", 32'(uo_out), 32'h00);
    b = busy_cnt;
    wr_mat(64'h01020304_05060708);
    chk("t4b_busy", 32'(busy_cnt - b), 32'd4);
    chk("t4b_flags", 32'(uo_out), 32'h02);
    rd_res(r, oe);
    chk_res("t4b", r, 64'h0013_0016_002B_0032);

    // unknown command is ignored
    start(4'h7);
    for (int k = 0; k < 5; k++) nib(4'(k + 3));
    chk("t5_oe", 32'(uio_oe), 32'h00);
    stop();
    chk("t5_flags", 32'(uo_out), 32'h02);
    rd_res(r, oe);
    chk_res("t5", r, 64'h0013_0016_002B_0032);

    // reset in the middle of COMPUTE
    start(4'h1);
    for (int k = 0; k < 15; k++) nib(4'hF);
    sclk = 1'b0; dq = 4'hF; wait_n(6);
    sclk = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = uo_out[0];
    end
    chk("t6_busy_seen", 32'(seen), 32'd1);
    rst = 1'b1; #1;
    chk("t6_rst_uo", 32'(uo_out), 32'h00);
    chk("t6_rst_oe", 32'(uio_oe), 32'h00);
    cs_n = 1'b1; sclk = 1'b0;
    wait_n(3);
    rst = 1'b0; wait_n(4);
    rd_res(r, oe);
    chk_res("t6", r, 64'h0);
    chk("t6_flags", 32'(uo_out), 32'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
